// File: rtl/ngs_pkg.sv
// Shared types and constants for the NGS Z80-side memory pager.
package ngs_pkg;

   typedef logic [7:0] page_t;

   localparam logic [7:0] PORT_MPAG_DEF   = 8'h00;
   localparam logic [7:0] PORT_MPAGEX_DEF = 8'h10;
   localparam logic [7:0] PORT_CFG_DEF    = 8'h0F;

   localparam int CFG_EXPAG = 0;
   localparam int CFG_RAM0  = 1;

   // Result of window decode: ROM pages use page[4:0] only.
   typedef struct packed {
      logic  is_rom;
      page_t page;
   } map_t;

endpackage

// File: rtl/ngs_page_regs.sv
// Page/config registers loaded by Z80 I/O writes; outputs read as zero while rst is high.
module ngs_page_regs
   import ngs_pkg::*;
#(
   parameter logic [7:0] PORT_MPAG   = PORT_MPAG_DEF,
   parameter logic [7:0] PORT_MPAGEX = PORT_MPAGEX_DEF,
   parameter logic [7:0] PORT_CFG    = PORT_CFG_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] a_lo_i,
   input  logic [7:0] d_i,
   input  logic       iorq_n_i,
   input  logic       wr_n_i,
   input  logic       m1_n_i,
   output page_t      mpag_o,
   output page_t      mpagex_o,
   output page_t      cfg_o
);

   page_t mpag_q, mpag_d;
   page_t mpagex_q, mpagex_d;
   page_t cfg_q, cfg_d;
   logic  io_wr;

   assign io_wr = !iorq_n_i && !wr_n_i && m1_n_i;

   always_comb begin
      mpag_d   = mpag_q;
      mpagex_d = mpagex_q;
      cfg_d    = cfg_q;
      if (io_wr) begin
         if (a_lo_i == PORT_MPAG)   mpag_d   = d_i;
         if (a_lo_i == PORT_MPAGEX) mpagex_d = d_i;
         if (a_lo_i == PORT_CFG)    cfg_d    = d_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mpag_q   <= '0;
         mpagex_q <= '0;
         cfg_q    <= '0;
      end else begin
         mpag_q   <= mpag_d;
         mpagex_q <= mpagex_d;
         cfg_q    <= cfg_d;
      end
   end

   // Masking lets an in-flight memory cycle see cleared registers before the reset edge.
   assign mpag_o   = rst ? '0 : mpag_q;
   assign mpagex_o = rst ? '0 : mpagex_q;
   assign cfg_o    = rst ? '0 : cfg_q;

endmodule

// File: rtl/ngs_mem_pager.sv
// Z80 memory pager: window decode to ROM/RAM chip selects, strobes and high address lines.
module ngs_mem_pager
   import ngs_pkg::*;
#(
   parameter logic [7:0] PORT_MPAG   = PORT_MPAG_DEF,
   parameter logic [7:0] PORT_MPAGEX = PORT_MPAGEX_DEF,
   parameter logic [7:0] PORT_CFG    = PORT_CFG_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] a,
   input  logic [7:0]  d,
   input  logic        mreq_n,
   input  logic        iorq_n,
   input  logic        rd_n,
   input  logic        wr_n,
   input  logic        m1_n,
   output logic        mema14,
   output logic        mema15,
   output logic        mema16,
   output logic        mema17,
   output logic        mema18,
   output logic        mema21,
   output logic        ram0cs_n,
   output logic        ram1cs_n,
   output logic        ram2cs_n,
   output logic        ram3cs_n,
   output logic        romcs_n,
   output logic        memoe_n,
   output logic        memwe_n
);

   page_t      mpag, mpagex, cfg;
   map_t       map;
   logic       cyc;
   logic       expag;
   logic [3:0] ram_sel;

   ngs_page_regs #(
      .PORT_MPAG   (PORT_MPAG),
      .PORT_MPAGEX (PORT_MPAGEX),
      .PORT_CFG    (PORT_CFG)
   ) u_regs (
      .clk      (clk),
      .rst      (rst),
      .a_lo_i   (a[7:0]),
      .d_i      (d),
      .iorq_n_i (iorq_n),
      .wr_n_i   (wr_n),
      .m1_n_i   (m1_n),
      .mpag_o   (mpag),
      .mpagex_o (mpagex),
      .cfg_o    (cfg)
   );

   assign expag = cfg[CFG_EXPAG];

   always_comb begin
      map.is_rom = 1'b0;
      map.page   = '0;
      case (a[15:14])
         2'd0: begin
            map.is_rom = !cfg[CFG_RAM0];
            map.page   = 8'h00;
         end
         2'd1: map.page = 8'h01;
         default: begin
            if (expag) begin
               map.page = a[14] ? mpagex : mpag;
            end else if (mpag[7]) begin
               map.is_rom = 1'b1;
               map.page   = {3'b000, mpag[3:0], a[14]};
            end else begin
               map.page   = {mpag[6:0], a[14]};
            end
         end
      endcase
   end

   assign cyc = !mreq_n && (!rd_n || !wr_n);

   always_comb begin
      ram_sel = 4'b0000;
      if (cyc && !map.is_rom) ram_sel[map.page[7:6]] = 1'b1;
   end

   assign {mema18, mema17, mema16, mema15, mema14} = map.page[4:0];
   assign mema21 = !map.is_rom && map.page[5];

   assign ram0cs_n = !ram_sel[0];
   assign ram1cs_n = !ram_sel[1];
   assign ram2cs_n = !ram_sel[2];
   assign ram3cs_n = !ram_sel[3];
   // ROM is write-protected: a write cycle never selects it.
   assign romcs_n  = !(cyc && map.is_rom && wr_n);

   assign memoe_n = mreq_n | rd_n;
   assign memwe_n = mreq_n | wr_n;

endmodule

// File: tb/tb_ngs_mem_pager.sv
// Scoreboard bench for ngs_mem_pager: directed bus cycles, negedge monitor compares.
module tb_ngs_mem_pager;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] a = '0;
   logic [7:0]  d = '0;
   logic        mreq_n = 1'b1, iorq_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1, m1_n = 1'b1;
   logic        mema14, mema15, mema16, mema17, mema18, mema21;
   logic        ram0cs_n, ram1cs_n, ram2cs_n, ram3cs_n, romcs_n, memoe_n, memwe_n;

   ngs_mem_pager dut (
      .clk(clk), .rst(rst), .a(a), .d(d),
      .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n),
      .mema14(mema14), .mema15(mema15), .mema16(mema16), .mema17(mema17), .mema18(mema18),
      .mema21(mema21),
      .ram0cs_n(ram0cs_n), .ram1cs_n(ram1cs_n), .ram2cs_n(ram2cs_n), .ram3cs_n(ram3cs_n),
      .romcs_n(romcs_n), .memoe_n(memoe_n), .memwe_n(memwe_n)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [3:0] ram_n;
      logic       rom_n;
      logic [5:0] pg;
      logic       oe_n;
      logic       we_n;
   } exp_t;

   exp_t sb[$];
   logic vec_valid = 1'b0;
   int   checks = 0;
   int   errors = 0;

   // chip: 0..3 RAM chip, 4 ROM; pg = {mema21, mema18..mema14}
   task automatic mem_cyc(input string nm, input logic [15:0] addr,
                          input bit mq, input bit rdv, input bit wrv,
                          input int chip, input logic [5:0] pg);
      exp_t e;
      bit   act;
      act     = !mq && (!rdv || !wrv);
      e.name  = nm;
      e.ram_n = 4'hF;
      e.rom_n = 1'b1;
      if (act && chip < 4) e.ram_n[chip[1:0]] = 1'b0;
      if (act && chip == 4 && wrv) e.rom_n = 1'b0;
      e.pg    = pg;
      e.oe_n  = mq | rdv;
      e.we_n  = mq | wrv;
      a = addr; mreq_n = mq; rd_n = rdv; wr_n = wrv;
      sb.push_back(e);
      vec_valid = 1'b1;
      @(posedge clk); #1;
      vec_valid = 1'b0;
      mreq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
   endtask

   task automatic io_wr(input logic [15:0] addr, input logic [7:0] data, input bit m1v);
      a = addr; d = data; iorq_n = 1'b0; wr_n = 1'b0; m1_n = m1v;
      @(posedge clk); #1;
      iorq_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1;
   endtask

   initial begin : monitor
      exp_t       e;
      logic [3:0] ram_g;
      logic [5:0] pg_g;
      forever begin
         @(negedge clk);
         if (vec_valid) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL %0t: output presented with empty scoreboard", $time);
            end else begin
               e     = sb.pop_front();
               ram_g = {ram3cs_n, ram2cs_n, ram1cs_n, ram0cs_n};
               pg_g  = {mema21, mema18, mema17, mema16, mema15, mema14};
               if (ram_g !== e.ram_n || romcs_n !== e.rom_n || pg_g !== e.pg ||
                   memoe_n !== e.oe_n || memwe_n !== e.we_n) begin
                  errors++;
                  $display("FAIL %s: got ram_n=%b rom_n=%b pg=%h oe_n=%b we_n=%b, want ram_n=%b rom_n=%b pg=%h oe_n=%b we_n=%b",
                           e.name, ram_g, romcs_n, pg_g, memoe_n, memwe_n,
                           e.ram_n, e.rom_n, e.pg, e.oe_n, e.we_n);
               end
            end
         end
      end
   end

   initial begin
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      mem_cyc("rd_0123_in_reset", 16'h0123, 0, 0, 1, 4, 6'h00);
      rst = 1'b0;
      mem_cyc("rd_0123",          16'h0123, 0, 0, 1, 4, 6'h00);
      mem_cyc("idle_mreq_high",   16'h4000, 1, 0, 1, 0, 6'h01);
      mem_cyc("rd_4000",          16'h4000, 0, 0, 1, 0, 6'h01);
      mem_cyc("rd_8000_mpag0",    16'h8000, 0, 0, 1, 0, 6'h00);
      mem_cyc("rd_c000_mpag0",    16'hC000, 0, 0, 1, 0, 6'h01);

      io_wr(16'h0000, 8'h05, 1);
      mem_cyc("rd_c000_ram0b",    16'hC000, 0, 0, 1, 0, 6'h0B);
      mem_cyc("rd_8000_ram0a",    16'h8000, 0, 0, 1, 0, 6'h0A);

      io_wr(16'h0000, 8'h85, 1);
      mem_cyc("rd_c000_rom0b",    16'hC000, 0, 0, 1, 4, 6'h0B);

      io_wr(16'h0000, 8'hC3, 1);
      mem_cyc("rd_c000_rom07",    16'hC000, 0, 0, 1, 4, 6'h07);
      mem_cyc("wr_c000_rom_wp",   16'hC000, 0, 1, 0, 4, 6'h07);
      mem_cyc("rd_8000_rom06",    16'h8000, 0, 0, 1, 4, 6'h06);

      io_wr(16'h0000, 8'h05, 0);
      mem_cyc("m1_blocks_write",  16'hC000, 0, 0, 1, 4, 6'h07);

      io_wr(16'hAB0F, 8'h01, 1);
      io_wr(16'h1200, 8'h7F, 1);
      io_wr(16'h0010, 8'hE0, 1);
      mem_cyc("rd_8000_expag",    16'h8000, 0, 0, 1, 1, 6'h3F);
      mem_cyc("rd_c000_expag",    16'hC000, 0, 0, 1, 3, 6'h20);
      mem_cyc("wr_8000_ram1",     16'h8000, 0, 1, 0, 1, 6'h3F);

      io_wr(16'h0011, 8'h00, 1);
      mem_cyc("wrong_port",       16'hC000, 0, 0, 1, 3, 6'h20);

      io_wr(16'h000F, 8'h02, 1);
      mem_cyc("rd_0000_ram0",     16'h0000, 0, 0, 1, 0, 6'h00);
      mem_cyc("rd_c000_ramff",    16'hC000, 0, 0, 1, 3, 6'h3F);

      rst = 1'b1;
      mem_cyc("rd_0000_rst_mid",  16'h0000, 0, 0, 1, 4, 6'h00);
      rst = 1'b0;
      mem_cyc("rd_0000_post_rst", 16'h0000, 0, 0, 1, 4, 6'h00);
      mem_cyc("rd_c000_post_rst", 16'hC000, 0, 0, 1, 0, 6'h01);

      repeat (2) @(posedge clk);
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
